// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the bus-ownership controller: transfer/burst
// encodings, controller state type and small constant helpers.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   // Beat counter width: large enough to hold the longest fixed burst (16).
   localparam int BEAT_W = 5;

   typedef enum logic [1:0] {
      PARK = 2'd0,   // default master parked, nobody owns the bus
      OWN  = 2'd1,   // a requesting master owns the bus, unlocked
      LOCK = 2'd2    // owner runs a locked sequence, arbiter sees only it
   } grant_state_e;

   // Number of beats in a fixed-length burst; 0 for undefined-length INCR.
   function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
      logic [BEAT_W-1:0] len;
      case (hburst)
         HBURST_SINGLE:               len = 5'd1;
         HBURST_INCR:                 len = 5'd0;
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
         default:                     len = 5'd0;
      endcase
      return len;
   endfunction

   // Ceiling log2, never less than 1 so index vectors stay non-empty.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/ahb_grant_ctrl_if.sv
// Master-side request lines and controller-driven ownership signals.
// The controller uses the slave modport; the masters/bench use master.
interface ahb_grant_ctrl_if #(
   parameter int NUM_MST = 5,
   parameter int IDW     = ahb_pkg::clog2(NUM_MST)
);
   logic [NUM_MST-1:0] hbusreq;
   logic [NUM_MST-1:0] hlock;
   logic [1:0]         htrans;
   logic [2:0]         hburst;
   logic               hready;
   logic [NUM_MST-1:0] hgrant;
   logic [IDW-1:0]     hmaster;
   logic [IDW-1:0]     hmaster_d;
   logic               hmastlock;

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster, hmaster_d, hmastlock
   );

   modport master (
      output hbusreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster, hmaster_d, hmastlock
   );
endinterface

// File: rtl/ahb_grant_ctrl_arbiter.sv
// Combinational fixed-priority arbiter, req[0] highest priority.
// pre_id msb set means no request; low bits are the winner index.
module arbiter #(
   parameter int WIDTH = 5,
   parameter int BITW  = 3
) (
   input  logic [WIDTH-1:0] req,
   output logic [BITW:0]    pre_id
);

   // Scan from the lowest priority upward so the lowest set index wins last.
   always_comb begin
      pre_id = {1'b1, {BITW{1'b0}}};
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) pre_id = {1'b0, BITW'(i)};
      end
   end

endmodule

// File: rtl/ahb_grant_ctrl.sv
// AHB bus-ownership controller around a fixed-priority arbiter: masks
// requests during locked sequences, holds grant across fixed bursts, parks
// on the default master and pipelines hmaster/hmaster_d/hmastlock.
module ahb_grant_ctrl
   import ahb_pkg::*;
#(
   parameter int NUM_MST     = 5,
   parameter int IDW         = clog2(NUM_MST),
   parameter int DEFAULT_MST = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   ahb_grant_ctrl_if.slave    bus,
   output logic [NUM_MST-1:0] arb_req,
   output logic [IDW:0]       arb_pre_id
);

   localparam logic [IDW-1:0]     DEF_IDX   = IDW'(DEFAULT_MST);
   localparam logic [NUM_MST-1:0] DEF_GRANT = NUM_MST'(1) << DEFAULT_MST;

   grant_state_e        state_reg, state_next;
   logic [NUM_MST-1:0]  hgrant_reg, hgrant_next;
   logic [IDW-1:0]      grant_idx_reg, grant_idx_next;
   logic [IDW-1:0]      hmaster_reg, hmaster_d_reg;
   logic                hmastlock_reg;
   logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
   logic [BEAT_W-1:0]   beat_idx;
   logic [IDW-1:0]      new_grant;
   logic [NUM_MST-1:0]  owner_onehot;
   logic                hp;

   arbiter #(
      .WIDTH (NUM_MST),
      .BITW  (IDW)
   ) u_arbiter (
      .req    (arb_req),
      .pre_id (arb_pre_id)
   );

   // Decode of the current address-phase owner, used as the locked request mask.
   for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_owner
      assign owner_onehot[gi] = (hmaster_reg == IDW'(gi));
   end

   assign new_grant = arb_pre_id[IDW] ? DEF_IDX : arb_pre_id[IDW-1:0];

   // During a locked sequence only the owner is visible to the arbiter.
   always_comb begin
      arb_req = bus.hbusreq;
      if (state_reg == LOCK) arb_req = owner_onehot;
   end

   // Beat tracking and handover-point detection for the current owner's transfer.
   always_comb begin
      beat_idx      = (bus.htrans == HTRANS_NONSEQ) ? 5'd1 : beat_cnt_reg + 5'd1;
      beat_cnt_next = beat_cnt_reg;
      if (bus.hready) begin
         case (bus.htrans)
            HTRANS_IDLE:   beat_cnt_next = '0;
            HTRANS_NONSEQ: beat_cnt_next = 5'd1;
            HTRANS_SEQ:    beat_cnt_next = beat_cnt_reg + 5'd1;
            default:       beat_cnt_next = beat_cnt_reg;
         endcase
      end
      // BUSY never hands over; unfinished fixed bursts keep the grant.
      hp = bus.hready &&
           ((bus.htrans == HTRANS_IDLE) ||
            ((bus.htrans != HTRANS_BUSY) &&
             ((bus.hburst == HBURST_INCR) || (beat_idx == burst_len(bus.hburst)))));
   end

   // Ownership FSM: decides when the grant may move and tracks lock state.
   always_comb begin
      state_next     = state_reg;
      grant_idx_next = grant_idx_reg;
      case (state_reg)
         PARK: begin
            // Parked: follow the arbiter every cycle, even while the bus stalls.
            grant_idx_next = new_grant;
            if (bus.hbusreq[new_grant]) state_next = OWN;
         end
         OWN: begin
            if (hp) grant_idx_next = new_grant;
            if (hp && arb_pre_id[IDW]) begin
               state_next = PARK;
            end else if (bus.hready && bus.hlock[grant_idx_reg] &&
                         (!hp || (new_grant == grant_idx_reg))) begin
               // hmastlock sets this edge for a master that keeps the grant.
               state_next = LOCK;
            end
         end
         LOCK: begin
            // Arbiter only sees the owner, so the grant cannot move here.
            if (hp && !bus.hlock[hmaster_reg])
               state_next = bus.hbusreq[hmaster_reg] ? OWN : PARK;
         end
         default: state_next = PARK;
      endcase
      hgrant_next = NUM_MST'(1) << grant_idx_next;
   end

   // Grant and FSM state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= PARK;
         grant_idx_reg <= DEF_IDX;
         hgrant_reg    <= DEF_GRANT;
      end else begin
         state_reg     <= state_next;
         grant_idx_reg <= grant_idx_next;
         hgrant_reg    <= hgrant_next;
      end
   end

   // Address->data ownership pipeline, advanced only when the bus is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hmaster_reg   <= DEF_IDX;
         hmaster_d_reg <= DEF_IDX;
         hmastlock_reg <= 1'b0;
         beat_cnt_reg  <= '0;
      end else begin
         beat_cnt_reg <= beat_cnt_next;
         if (bus.hready) begin
            hmaster_reg   <= grant_idx_reg;
            hmaster_d_reg <= hmaster_reg;
            hmastlock_reg <= bus.hlock[grant_idx_reg];
         end
      end
   end

   assign bus.hgrant    = hgrant_reg;
   assign bus.hmaster   = hmaster_reg;
   assign bus.hmaster_d = hmaster_d_reg;
   assign bus.hmastlock = hmastlock_reg;

endmodule
